// File: rtl/led_display_pattern_gen_fx.sv
`default_nettype none
// ============================================================================
// Module   : led_display_pattern_gen_fx
// Purpose  : Streams half-panel row pairs (top + bottom half rows, 1 bit per
//            colour per pixel) over a valid/ready link. Supports OFF, SOLID,
//            horizontal scan, vertical scan and a triangle-ramp PWM pulse.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module led_display_pattern_gen_fx #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int PWM_BITS       = 4,
  parameter int STEP_FRAMES    = 1
) (
  input  logic                                    clk_in,
  input  logic                                    n_reset_in,
  input  logic [3:0]                              mode_in,
  input  logic [2:0]                              colour_in,
  output logic [6*NUM_COL_PIXELS-1:0]             row_out,
  output logic                                    row_valid_out,
  input  logic                                    row_ready_in,
  output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]     row_address_out
);

  localparam int H  = NUM_ROW_PIXELS / 2;
  localparam int AW = $clog2(H);
  localparam int VW = AW + 1;                       // indexes all panel rows
  localparam int NC = NUM_COL_PIXELS;
  localparam int CW = $clog2(NUM_COL_PIXELS);
  localparam int SW = $clog2(STEP_FRAMES + 1);
  localparam int RW = 6 * NUM_COL_PIXELS;

  localparam logic [3:0] MODE_SOLID  = 4'd1;
  localparam logic [3:0] MODE_SCAN_H = 4'd2;
  localparam logic [3:0] MODE_SCAN_V = 4'd3;
  localparam logic [3:0] MODE_PULSE  = 4'd4;

  localparam logic [AW-1:0]       ADDR_LAST = AW'(H - 1);
  localparam logic [VW-1:0]       V_LAST    = VW'(NUM_ROW_PIXELS - 1);
  localparam logic [VW-1:0]       V_HALF    = VW'(H);
  localparam logic [CW-1:0]       COL_LAST  = CW'(NUM_COL_PIXELS - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

  typedef enum logic [0:0] {
    ST_RESTART = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            mode_q, mode_d;
  logic [2:0]            colour_q, colour_d;
  logic                  init_done_q, init_done_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         scan_h_q, scan_h_d;
  logic [VW-1:0]         scan_v_q, scan_v_d;
  logic [SW-1:0]         step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic                  dir_down_q, dir_down_d;
  logic                  step_pend_q, step_pend_d;
  logic                  step_now;
  logic                  load_row;

  // Expand the effect state into the six colour fields for one address.
  function automatic logic [RW-1:0] build_row(
    input logic [3:0]          md,
    input logic [2:0]          col_rgb,
    input logic [AW-1:0]       a,
    input logic [CW-1:0]       hpos,
    input logic [VW-1:0]       vpos,
    input logic [PWM_BITS-1:0] pwm,
    input logic [PWM_BITS-1:0] bright
  );
    logic [NC-1:0] top_lit;
    logic [NC-1:0] bot_lit;
    top_lit = '0;
    bot_lit = '0;
    case (md)
      MODE_SOLID: begin
        top_lit = '1;
        bot_lit = '1;
      end
      MODE_SCAN_H: begin
        top_lit = NC'(1) << hpos;
        bot_lit = top_lit;
      end
      MODE_SCAN_V: begin
        top_lit = {NC{vpos == {1'b0, a}}};
        bot_lit = {NC{vpos == ({1'b0, a} + V_HALF)}};
      end
      MODE_PULSE: begin
        top_lit = {NC{pwm < bright}};
        bot_lit = top_lit;
      end
      default: begin
        top_lit = '0;
        bot_lit = '0;
      end
    endcase
    return {top_lit & {NC{col_rgb[0]}}, top_lit & {NC{col_rgb[1]}},
            top_lit & {NC{col_rgb[2]}}, bot_lit & {NC{col_rgb[0]}},
            bot_lit & {NC{col_rgb[1]}}, bot_lit & {NC{col_rgb[2]}}};
  endfunction

  // Next-state, handshake, frame/step accounting and row generation.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_in;
    colour_d    = colour_in;
    init_done_d = 1'b1;
    addr_d      = addr_q;
    row_d       = row_q;
    scan_h_d    = scan_h_q;
    scan_v_d    = scan_v_q;
    step_cnt_d  = step_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    bright_d    = bright_q;
    dir_down_d  = dir_down_q;
    step_pend_d = step_pend_q;
    step_now    = 1'b0;
    load_row    = 1'b0;

    case (state_q)
      ST_RESTART: begin
        addr_d      = '0;
        scan_h_d    = '0;
        scan_v_d    = '0;
        step_cnt_d  = '0;
        pwm_cnt_d   = '0;
        bright_d    = '0;
        dir_down_d  = 1'b0;
        step_pend_d = 1'b0;
        // Wait for the registered mode to settle so the first row uses it.
        if (init_done_q && (mode_in == mode_q)) begin
          state_d  = ST_RUN;
          load_row = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_in != mode_q) begin
          state_d = ST_RESTART;
        end else if (row_ready_in) begin
          load_row = 1'b1;
          if (addr_q == ADDR_LAST) begin
            addr_d     = '0;
            step_now   = (step_cnt_q == STEP_LAST);
            step_cnt_d = step_now ? '0 : step_cnt_q + 1'b1;
            if (step_now) begin
              scan_h_d = (scan_h_q == COL_LAST) ? '0 : scan_h_q + 1'b1;
              scan_v_d = (scan_v_q == V_LAST)   ? '0 : scan_v_q + 1'b1;
            end
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == PWM_MAX) begin
              // Brightness only moves on a PWM period boundary.
              if (step_now || step_pend_q) begin
                step_pend_d = 1'b0;
                if (dir_down_q) begin
                  if (bright_q == '0) begin
                    dir_down_d = 1'b0;
                    bright_d   = PWM_ONE;
                  end else begin
                    bright_d = bright_q - 1'b1;
                  end
                end else begin
                  if (bright_q == PWM_MAX) begin
                    dir_down_d = 1'b1;
                    bright_d   = PWM_MAX - 1'b1;
                  end else begin
                    bright_d = bright_q + 1'b1;
                  end
                end
              end
            end else if (step_now) begin
              step_pend_d = 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RESTART;
    endcase

    // New rows always reflect the effect state after this cycle's update.
    if (load_row) begin
      row_d = build_row(mode_q, colour_q, addr_d, scan_h_d, scan_v_d,
                        pwm_cnt_d, bright_d);
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q     <= ST_RESTART;
      mode_q      <= '0;
      colour_q    <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      scan_h_q    <= '0;
      scan_v_q    <= '0;
      step_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      bright_q    <= '0;
      dir_down_q  <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      colour_q    <= colour_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      scan_h_q    <= scan_h_d;
      scan_v_q    <= scan_v_d;
      step_cnt_q  <= step_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      bright_q    <= bright_d;
      dir_down_q  <= dir_down_d;
      step_pend_q <= step_pend_d;
    end
  end

  assign row_out         = row_q;
  assign row_valid_out   = (state_q == ST_RUN);
  assign row_address_out = addr_q;

endmodule
`default_nettype wire
